// File: rtl/data_mem_pipe.sv
// Word-organised data RAM behind a valid/ready request port with a fixed-latency
// read pipeline, first-word-fall-through response FIFO and credit-based request flow control.
module data_mem_pipe #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int DEPTH_P           = 256,
    parameter int RD_LATENCY_P      = 2,
    parameter int RSP_DEPTH_P       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_wr_en,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_req_addr,
    input  logic [DATA_WIDTH_P/8-1:0]    i_req_byte_en,
    input  logic [DATA_WIDTH_P-1:0]      i_req_wr_data,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [DATA_WIDTH_P-1:0]      o_rsp_rd_data,
    output logic                         o_rsp_err
);

    localparam int BE_W  = DATA_WIDTH_P / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH_P);
    localparam int CNT_W = $clog2(RSP_DEPTH_P + 1);
    localparam int PTR_W = (RSP_DEPTH_P > 1) ? $clog2(RSP_DEPTH_P) : 1;
    localparam logic [DATA_ADDR_WIDTH_P-1:0] OFF_MASK = DATA_ADDR_WIDTH_P'((64'd1 << OFF_W) - 64'd1);

    logic [DATA_WIDTH_P-1:0] ram_r [DEPTH_P];

    logic                    ready_r;
    logic [CNT_W-1:0]        credit_r;
    logic [CNT_W-1:0]        credit_nx_s;

    logic [IDX_W-1:0]        idx_s;
    logic                    err_s;
    logic                    acc_rd_s;
    logic                    acc_wr_s;
    logic [DATA_WIDTH_P-1:0] rd_word_s;

    logic                    fifo_push_s;
    logic [DATA_WIDTH_P-1:0] fifo_push_d_s;
    logic                    fifo_push_e_s;
    logic                    pop_s;

    logic [DATA_WIDTH_P-1:0] fifo_d_r [RSP_DEPTH_P];
    logic                    fifo_e_r [RSP_DEPTH_P];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        fifo_cnt_r;
    logic [CNT_W-1:0]        fifo_cnt_nx_s;
    logic                    rsp_valid_r;

    // Request decode: word index, error classification and acceptance qualifiers.
    always_comb begin
        idx_s     = i_req_addr[OFF_W +: IDX_W];
        err_s     = (|(i_req_addr & OFF_MASK)) | (|(i_req_addr >> (OFF_W + IDX_W)));
        acc_rd_s  = i_req_valid & ready_r & ~reset & ~i_req_wr_en;
        acc_wr_s  = i_req_valid & ready_r & ~reset & i_req_wr_en & ~err_s;
        if (err_s) begin
            rd_word_s = {DATA_WIDTH_P{1'b0}};
        end else begin
            rd_word_s = ram_r[idx_s];
        end
    end

    // Byte-lane RAM write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (acc_wr_s) begin
            for (int k = 0; k < BE_W; k++) begin
                if (i_req_byte_en[k]) begin
                    ram_r[idx_s][k*8 +: 8] <= i_req_wr_data[k*8 +: 8];
                end
            end
        end
    end

    // The FIFO write is the last latency stage, so only RD_LATENCY_P-1 registers precede it.
    generate
        if (RD_LATENCY_P == 1) begin : g_no_pipe
            assign fifo_push_s   = acc_rd_s;
            assign fifo_push_d_s = rd_word_s;
            assign fifo_push_e_s = err_s;
        end else begin : g_pipe
            logic [RD_LATENCY_P-2:0] pv_r;
            logic [DATA_WIDTH_P-1:0] pd_r [RD_LATENCY_P-1];
            logic                    pe_r [RD_LATENCY_P-1];

            // Read pipeline shift: valids are cleared on reset, payload is don't-care when invalid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pv_r <= {(RD_LATENCY_P-1){1'b0}};
                end else begin
                    pv_r[0] <= acc_rd_s;
                    for (int k = 1; k < RD_LATENCY_P - 1; k++) begin
                        pv_r[k] <= pv_r[k-1];
                    end
                end
                pd_r[0] <= rd_word_s;
                pe_r[0] <= err_s;
                for (int k = 1; k < RD_LATENCY_P - 1; k++) begin
                    pd_r[k] <= pd_r[k-1];
                    pe_r[k] <= pe_r[k-1];
                end
            end

            assign fifo_push_s   = pv_r[RD_LATENCY_P-2];
            assign fifo_push_d_s = pd_r[RD_LATENCY_P-2];
            assign fifo_push_e_s = pe_r[RD_LATENCY_P-2];
        end
    endgenerate

    // Next-state arithmetic for the credit counter and FIFO occupancy.
    always_comb begin
        pop_s = rsp_valid_r & i_rsp_ready;
        case ({acc_rd_s, pop_s})
            2'b10:   credit_nx_s = credit_r + CNT_W'(1);
            2'b01:   credit_nx_s = credit_r - CNT_W'(1);
            default: credit_nx_s = credit_r;
        endcase
        case ({fifo_push_s, pop_s})
            2'b10:   fifo_cnt_nx_s = fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_nx_s = fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_nx_s = fifo_cnt_r;
        endcase
    end

    // Credit, ready and FIFO control state; credit guarantees the FIFO never overflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_r    <= {CNT_W{1'b0}};
            ready_r     <= 1'b1;
            fifo_cnt_r  <= {CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
        end else begin
            credit_r    <= credit_nx_s;
            ready_r     <= (credit_nx_s < CNT_W'(RSP_DEPTH_P));
            fifo_cnt_r  <= fifo_cnt_nx_s;
            rsp_valid_r <= (fifo_cnt_nx_s != {CNT_W{1'b0}});
            if (fifo_push_s) begin
                if (wr_ptr_r == PTR_W'(RSP_DEPTH_P - 1)) begin
                    wr_ptr_r <= {PTR_W{1'b0}};
                end else begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
            end
            if (pop_s) begin
                if (rd_ptr_r == PTR_W'(RSP_DEPTH_P - 1)) begin
                    rd_ptr_r <= {PTR_W{1'b0}};
                end else begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (fifo_push_s && !reset) begin
            fifo_d_r[wr_ptr_r] <= fifo_push_d_s;
            fifo_e_r[wr_ptr_r] <= fifo_push_e_s;
        end
    end

    // Output drive from registered state only.
    always_comb begin
        o_req_ready = ready_r;
        o_rsp_valid = rsp_valid_r;
        if (rsp_valid_r) begin
            o_rsp_rd_data = fifo_d_r[rd_ptr_r];
            o_rsp_err     = fifo_e_r[rd_ptr_r];
        end else begin
            o_rsp_rd_data = {DATA_WIDTH_P{1'b0}};
            o_rsp_err     = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: a queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_mem_pipe;

    localparam int L  = 2;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wr_en;
    logic [31:0] i_req_addr;
    logic [3:0]  i_req_byte_en;
    logic [31:0] i_req_wr_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rd_data;
    logic        o_rsp_err;

    data_mem_pipe #(
        .DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32), .DEPTH_P(256),
        .RD_LATENCY_P(L), .RSP_DEPTH_P(RD)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wr_en(i_req_wr_en), .i_req_addr(i_req_addr),
        .i_req_byte_en(i_req_byte_en), .i_req_wr_data(i_req_wr_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rd_data(o_rsp_rd_data), .o_rsp_err(o_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          avail;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mram [256];
    int          credit;
    int          cyc;
    int          checks;
    int          fails;
    int          n_acc;
    int          n_valid;
    logic [31:0] last_d;
    logic        last_e;
    logic [31:0] w0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare DUT against model at negedge, drive inputs, advance the model at posedge.
    task automatic step(input logic v, input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic rr, input logic rst);
        logic exp_rdy;
        logic exp_v;
        logic acc;
        logic pop;
        logic err;
        int   idx;
        rsp_t r;
        exp_rdy = (credit < RD);
        exp_v   = (q.size() > 0) && (q[0].avail <= cyc);
        chk("req_ready", {31'd0, o_req_ready}, {31'd0, exp_rdy});
        chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, exp_v});
        if (exp_v) begin
            chk("rsp_data", o_rsp_rd_data, q[0].d);
            chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, q[0].e});
        end
        if (o_rsp_valid) n_valid++;
        if (v && o_req_ready && !rst) n_acc++;
        if (exp_v && rr && !rst) begin
            last_d = o_rsp_rd_data;
            last_e = o_rsp_err;
        end
        reset         = rst;
        i_req_valid   = v;
        i_req_wr_en   = we;
        i_req_addr    = a;
        i_req_byte_en = be;
        i_req_wr_data = wd;
        i_rsp_ready   = rr;
        acc = v && exp_rdy && !rst;
        pop = exp_v && rr && !rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            credit = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                credit--;
            end
            if (acc) begin
                err = (a[1:0] != 2'd0) || (a[31:10] != 22'd0);
                idx = int'(a[9:2]);
                if (we) begin
                    if (!err) begin
                        for (int k = 0; k < 4; k++) begin
                            if (be[k]) mram[idx][k*8 +: 8] = wd[k*8 +: 8];
                        end
                    end
                end else begin
                    r.d     = err ? 32'd0 : mram[idx];
                    r.e     = err;
                    r.avail = cyc + L - 1;
                    q.push_back(r);
                    credit++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, rr, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1'b1, 1'b1, a, be, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic rr);
        step(1'b1, 1'b0, a, 4'd0, 32'd0, rr, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            idle(1, 1'b1);
            n++;
        end
        chk("drain_timeout", {31'd0, (q.size() > 0)}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          ridx;
        int          sel;
        checks = 0; fails = 0; cyc = 0; credit = 0; n_acc = 0; n_valid = 0;
        last_d = 32'd0; last_e = 1'b0;
        reset = 1'b1; i_req_valid = 1'b0; i_req_wr_en = 1'b0; i_req_addr = 32'd0;
        i_req_byte_en = 4'd0; i_req_wr_data = 32'd0; i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b1, 32'd0, 4'hF, 32'hBAD0BAD0, 1'b1, 1'b1);

        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_data", o_rsp_rd_data, 32'd0);
        chk("rst_err", {31'd0, o_rsp_err}, 32'd0);

        for (int i = 0; i < 16; i++) wr(32'(i * 4), 4'hF, $urandom);
        w0 = mram[0];

        // Write then read: response two cycles after acceptance.
        wr(32'h10, 4'hF, 32'hDEADBEEF);
        rd(32'h10, 1'b1);
        chk("lat_not_yet", {31'd0, o_rsp_valid}, 32'd0);
        idle(1, 1'b1);
        chk("lat_valid", {31'd0, o_rsp_valid}, 32'd1);
        idle(1, 1'b1);
        chk("t1_data", last_d, 32'hDEADBEEF);
        chk("t1_err", {31'd0, last_e}, 32'd0);

        // Byte-lane merge.
        wr(32'h20, 4'hF, 32'h11223344);
        wr(32'h20, 4'b0101, 32'hAABBCCDD);
        rd(32'h20, 1'b1);
        drain();
        chk("t2_data", last_d, 32'h11BB33DD);

        // Backpressure: only RSP_DEPTH_P reads accepted.
        n_acc = 0;
        for (int i = 0; i < 6; i++) rd(32'(i * 4), 1'b0);
        chk("t3_accepted", 32'(n_acc), 32'd4);
        chk("t3_ready_low", {31'd0, o_req_ready}, 32'd0);
        drain();

        // Error reads and a dropped write.
        rd(32'h22, 1'b1);
        drain();
        chk("t4_mis_data", last_d, 32'd0);
        chk("t4_mis_err", {31'd0, last_e}, 32'd1);
        rd(32'h400, 1'b1);
        drain();
        chk("t4_oor_data", last_d, 32'd0);
        chk("t4_oor_err", {31'd0, last_e}, 32'd1);
        wr(32'h400, 4'hF, 32'hCAFEF00D);
        rd(32'h0, 1'b1);
        drain();
        chk("t4_word0", last_d, w0);

        // Streaming at one read per cycle.
        n_acc = 0; n_valid = 0;
        for (int i = 0; i < 16; i++) rd(32'((i % 16) * 4), 1'b1);
        idle(L, 1'b1);
        chk("t5_accepts", 32'(n_acc), 32'd16);
        chk("t5_responses", 32'(n_valid), 32'd16);

        // Reset with reads in flight.
        rd(32'h10, 1'b1); rd(32'h20, 1'b1); rd(32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        n_valid = 0;
        idle(6, 1'b1);
        chk("t6_no_rsp", 32'(n_valid), 32'd0);
        rd(32'h10, 1'b1);
        drain();
        chk("t6_keep", last_d, 32'hDEADBEEF);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ridx = $urandom_range(15, 0);
            sel  = $urandom_range(19, 0);
            if (sel == 0) a = 32'(ridx * 4) | 32'($urandom_range(3, 1));
            else if (sel == 1) a = 32'h400 | 32'(ridx * 4);
            else a = 32'(ridx * 4);
            if ($urandom_range(99, 0) == 0)
                step(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, 1'b1);
            else
                step(1'($urandom_range(1, 0)), 1'($urandom_range(2, 0) == 0), a,
                     4'($urandom), $urandom, 1'($urandom_range(3, 0) != 0), 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
